// File: rtl/mig_tt_gen.sv
`default_nettype none
// ============================================================================
// Module   : mig_tt_gen
// Purpose  : Sequential truth-table generator for a run-time programmable
//            majority-inverter graph. It walks all 2^N_IN input patterns,
//            evaluates one majority gate per cycle, and streams the
//            truth table out as W-bit words over a valid/ready handshake.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            cfg_we/cfg_addr/cfg_data - gate slot / output-select writes
//            start, busy, done        - run control and status
//            tt_data/tt_idx/tt_valid/tt_ready - truth-table word stream
// Revision : 1.0 - initial release
// ============================================================================
module mig_tt_gen #(
    parameter int  N_IN    = 7,
    parameter int  N_GATES = 16,
    parameter int  W       = 32,
    localparam int NODES   = 1 + N_IN + N_GATES,
    localparam int SELW    = $clog2(NODES),
    localparam int FW      = SELW + 1,
    localparam int AW      = $clog2(N_GATES + 1),
    localparam int IW      = ((N_IN - $clog2(W)) < 1) ? 1 : (N_IN - $clog2(W))
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [3*FW-1:0] cfg_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    tt_data,
    output logic [IW-1:0]   tt_idx,
    output logic            tt_valid,
    input  logic            tt_ready
);

    localparam int NPAD = 2 ** SELW;
    localparam int GW   = (N_GATES > 1) ? $clog2(N_GATES) : 1;
    localparam int LW   = $clog2(W);

    localparam logic [N_IN-1:0] c_wmask = N_IN'(W - 1);
    localparam logic [N_IN-1:0] c_plast = {N_IN{1'b1}};
    localparam logic [GW-1:0]   c_glast = GW'(N_GATES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    logic [3*FW-1:0]   r_gate [N_GATES];
    logic [FW-1:0]     r_osel;
    logic [N_GATES-1:0] r_w;
    logic [N_IN-1:0]   r_p;
    logic [GW-1:0]     r_g;
    logic [W-1:0]      r_acc;
    logic [1:0]        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic [W-1:0]      r_tt_data;
    logic [IW-1:0]     r_tt_idx;

    // Node vector in index order: const 0, x0.., w0..; indices past NODES read 0.
    logic [NPAD-1:0]   w_nodes;
    logic [3*FW-1:0]   w_cur;
    logic              w_a, w_b, w_c, w_maj, w_f;
    logic [W-1:0]      w_acc_next;
    logic              w_word_end;
    logic [IW-1:0]     w_idx;

    function automatic logic opval(input logic [FW-1:0] fld, input logic [NPAD-1:0] nodes);
        return nodes[fld[SELW-1:0]] ^ fld[FW-1];
    endfunction

    assign w_nodes    = NPAD'({r_w, r_p, 1'b0});
    assign w_cur      = r_gate[r_g];
    assign w_a        = opval(w_cur[0*FW +: FW], w_nodes);
    assign w_b        = opval(w_cur[1*FW +: FW], w_nodes);
    assign w_c        = opval(w_cur[2*FW +: FW], w_nodes);
    assign w_maj      = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
    assign w_f        = opval(r_osel, w_nodes);
    assign w_acc_next = r_acc | (W'(w_f) << (r_p & c_wmask));
    assign w_word_end = (r_p & c_wmask) == c_wmask;
    assign w_idx      = IW'(r_p >> LW);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_GATES; i++) r_gate[i] <= '0;
            r_osel    <= '0;
            r_w       <= '0;
            r_p       <= '0;
            r_g       <= '0;
            r_acc     <= '0;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_tt_data <= '0;
            r_tt_idx  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_we) begin
                        for (int i = 0; i < N_GATES; i++)
                            if (cfg_addr == AW'(i)) r_gate[i] <= cfg_data;
                        if (cfg_addr == AW'(N_GATES)) r_osel <= cfg_data[FW-1:0];
                    end
                    if (start) begin
                        // Gate nodes cleared so forward references start from 0.
                        r_w     <= '0;
                        r_p     <= '0;
                        r_g     <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_w[r_g] <= w_maj;
                    if (r_g == c_glast) begin
                        r_state <= S_CAP;
                    end else begin
                        r_g <= r_g + 1'b1;
                    end
                end
                S_CAP: begin
                    r_g <= '0;
                    if (w_word_end) begin
                        r_acc     <= w_acc_next;
                        r_tt_data <= w_acc_next;
                        r_tt_idx  <= w_idx;
                        r_valid   <= 1'b1;
                        r_state   <= S_EMIT;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_p     <= r_p + 1'b1;
                        r_state <= S_EVAL;
                    end
                end
                S_EMIT: begin
                    if (tt_ready) begin
                        r_valid <= 1'b0;
                        if (r_p == c_plast) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_p     <= r_p + 1'b1;
                            r_acc   <= '0;
                            r_state <= S_EVAL;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign tt_valid = r_valid;
    assign tt_data  = r_tt_data;
    assign tt_idx   = r_tt_idx;

endmodule
`default_nettype wire

// File: tb/tb_mig_tt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mig_tt_gen
// Purpose  : Self-checking bench for mig_tt_gen with default parameters.
//            Directed truth tables, backpressure, abort by reset and random
//            gate networks compared with a behavioural truth-table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mig_tt_gen;

    localparam int N_IN = 7, N_GATES = 16, W = 32;
    localparam int NODES = 1 + N_IN + N_GATES;
    localparam int NWORDS = (1 << N_IN) / W;
    localparam int BASE_DONE = (1 << N_IN) * (N_GATES + 1) + NWORDS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [17:0] cfg_data = '0;
    logic        start = 1'b0;
    logic        busy, done, tt_valid;
    logic        tt_ready = 1'b1;
    logic [31:0] tt_data;
    logic [1:0]  tt_idx;

    int checks = 0;
    int failures = 0;

    // Model configuration (what the DUT should currently hold).
    int   m_sel [N_GATES][3];
    bit   m_inv [N_GATES][3];
    int   m_osel;
    bit   m_oinv;
    logic [31:0] got [NWORDS];

    mig_tt_gen dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .busy(busy), .done(done),
        .tt_data(tt_data), .tt_idx(tt_idx), .tt_valid(tt_valid),
        .tt_ready(tt_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pk(input int s0, input bit i0, input int s1,
                                       input bit i1, input int s2, input bit i2);
        return {i2, 5'(s2), i1, 5'(s1), i0, 5'(s0)};
    endfunction

    task automatic model_clear();
        for (int g = 0; g < N_GATES; g++)
            for (int k = 0; k < 3; k++) begin m_sel[g][k] = 0; m_inv[g][k] = 0; end
        m_osel = 0; m_oinv = 0;
    endtask

    // Value of a node for pattern p given current gate values.
    function automatic bit nodeval(input int idx, input int p, input logic [N_GATES-1:0] wv);
        if (idx == 0) return 1'b0;
        if (idx <= N_IN) return 1'(p >> (idx - 1));
        if (idx < NODES) return wv[idx - N_IN - 1];
        return 1'b0;
    endfunction

    // Whole truth table: gates evaluated in order, values persisting across patterns.
    function automatic logic [127:0] model_tt();
        logic [N_GATES-1:0] wv = '0;
        logic [127:0] tt = '0;
        bit a, b, c;
        for (int p = 0; p < (1 << N_IN); p++) begin
            for (int g = 0; g < N_GATES; g++) begin
                a = nodeval(m_sel[g][0], p, wv) ^ m_inv[g][0];
                b = nodeval(m_sel[g][1], p, wv) ^ m_inv[g][1];
                c = nodeval(m_sel[g][2], p, wv) ^ m_inv[g][2];
                wv[g] = (int'(a) + int'(b) + int'(c)) >= 2;
            end
            tt[p] = nodeval(m_osel, p, wv) ^ m_oinv;
        end
        return tt;
    endfunction

    task automatic cfg_write(input int addr, input logic [17:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 5'(addr); cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (addr < N_GATES) begin
            for (int k = 0; k < 3; k++) begin
                m_sel[addr][k] = int'(data[k*6 +: 5]);
                m_inv[addr][k] = data[k*6 + 5];
            end
        end else if (addr == N_GATES) begin
            m_osel = int'(data[4:0]);
            m_oinv = data[5];
        end
    endtask

    // One full run; stall_word < 0 disables the backpressure episode.
    task automatic run(input string tag, input int stall_word, input int stall_len);
        logic [127:0] exp_tt = model_tt();
        int cyc = 0, nw = 0, exp_done = BASE_DONE + ((stall_word >= 0) ? stall_len : 0);
        bit got_done = 0, stalled = 0;
        logic [31:0] d0;
        logic [1:0] i0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        while (!got_done && cyc < 5000) begin
            @(posedge clk); cyc++; #1;
            if (done) begin
                got_done = 1;
                chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
                chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
                chk({tag, "_word_count"}, 64'(nw), 64'(NWORDS));
            end else if (tt_valid) begin
                if (nw == stall_word && !stalled) begin
                    stalled = 1;
                    tt_ready = 1'b0;
                    d0 = tt_data; i0 = tt_idx;
                    for (int s = 0; s < stall_len; s++) begin
                        if (s == 0) begin
                            cfg_we = 1'b1; cfg_addr = 5'd16; cfg_data = pk(1, 1, 0, 0, 0, 0);
                            start = 1'b1;
                        end
                        @(posedge clk); cyc++; #1;
                        cfg_we = 1'b0; start = 1'b0;
                        chk({tag, "_stall_data"}, 64'(tt_data), 64'(d0));
                        chk({tag, "_stall_idx"}, 64'(tt_idx), 64'(i0));
                        chk({tag, "_stall_busy"}, 64'(busy), 64'd1);
                    end
                    tt_ready = 1'b1;
                end
                if (nw < NWORDS) begin
                    got[nw] = tt_data;
                    chk({tag, "_word"}, 64'(tt_data), 64'(exp_tt[nw*32 +: 32]));
                    chk({tag, "_idx"}, 64'(tt_idx), 64'(nw));
                end
                nw++;
            end
        end
        if (!got_done) chk({tag, "_done_timeout"}, 64'(got_done), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int abort_done;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_valid", 64'(tt_valid), 64'd0);
        chk("reset_data", 64'(tt_data), 64'd0);
        chk("reset_idx", 64'(tt_idx), 64'd0);
        rst = 1'b0;

        // Unconfigured: constant 0.
        run("zero", -1, 0);

        // MAJ(x0,x1,x2); out-of-range address write must be ignored.
        cfg_write(0, pk(1, 0, 2, 0, 3, 0));
        cfg_write(16, pk(8, 0, 0, 0, 0, 0));
        cfg_write(20, pk(5, 1, 5, 1, 5, 1));
        run("maj", -1, 0);
        chk("maj_const_w0", 64'(got[0]), 64'h0000_0000_E8E8_E8E8);
        chk("maj_const_w3", 64'(got[3]), 64'h0000_0000_E8E8_E8E8);
        cfg_write(16, pk(8, 1, 0, 0, 0, 0));
        run("minority", -1, 0);
        chk("minority_const", 64'(got[2]), 64'h0000_0000_1717_1717);

        // out_sel = x6
        cfg_write(16, pk(7, 0, 0, 0, 0, 0));
        run("x6", -1, 0);
        chk("x6_w1", 64'(got[1]), 64'h0);
        chk("x6_w2", 64'(got[2]), 64'hFFFF_FFFF);

        // NAND via AND then inverted gate with constant 1.
        cfg_write(0, pk(1, 0, 2, 0, 0, 0));
        cfg_write(1, pk(8, 1, 0, 1, 0, 0));
        cfg_write(16, pk(9, 0, 0, 0, 0, 0));
        run("nand", -1, 0);
        chk("nand_const", 64'(got[0]), 64'h7777_7777);

        // Backpressure on word 1 with ignored cfg/start pulses.
        run("stall", 1, 10);

        // Random networks, including out-of-range node indices.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a <= N_GATES; a++)
                cfg_write(a, pk($urandom_range(0, 31), 1'($urandom), $urandom_range(0, 31),
                                1'($urandom), $urandom_range(0, 31), 1'($urandom)));
            cfg_write(16, pk($urandom_range(1, 25), 1'($urandom), 0, 0, 0, 0));
            cfg_write($urandom_range(17, 31), pk(3, 1, 4, 1, 5, 1));
            run("rand", -1, 0);
        end

        // Abort with reset during pattern 50.
        cfg_write(0, pk(1, 0, 2, 0, 3, 0));
        cfg_write(16, pk(8, 0, 0, 0, 0, 0));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50 * 17 + 1 + 8) @(posedge clk);
        #1;
        chk("abort_pre_data", 64'(tt_data), 64'hE8E8_E8E8);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_valid", 64'(tt_valid), 64'd0);
        chk("abort_data", 64'(tt_data), 64'd0);
        chk("abort_idx", 64'(tt_idx), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        abort_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) abort_done++;
        end
        chk("abort_quiet", 64'(abort_done), 64'd0);
        run("post_abort", -1, 0);
        chk("post_abort_w0", 64'(got[0]), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mig_tt_gen.md
# mig_tt_gen

Sequential truth-table generator for a run-time programmable majority-inverter graph (MIG) of up to `N_GATES` 3-input majority gates over `N_IN` primary inputs. It enumerates all 2^`N_IN` input patterns, evaluates the programmed network one gate per cycle, and streams the resulting truth table out in `W`-bit words over a valid/ready handshake. It sits in the classification flow next to the fixed-function MIG netlists and lets a single instance reproduce any of their truth tables by loading a gate list instead of re-synthesising.

## Interface
- `N_IN`, default 7: number of primary inputs x0..x(N_IN-1).
- `N_GATES`, default 16: number of gate slots w0..w(N_GATES-1).
- `W`, default 32: output word width. Must be a power of 2 and ≤ 2^N_IN.
- Derived values:
  - `NODES = 1+N_IN+N_GATES`.
  - `SELW = clog2(NODES)`.
  - `FW = SELW+1`.
  - `AW = clog2(N_GATES+1)`.
- Node index map: 0 = constant 0; 1..N_IN = x0..; N_IN+1.. = w0..
- `clk` in 1: the single clock; everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: configuration write strobe.
- `cfg_addr` in AW: 0..N_GATES-1 selects a gate slot; N_GATES selects the output-select register.
- `cfg_data` in 3*FW: operand field i is `cfg_data[i*FW +: FW]`. Within a field, bit FW-1 = invert and bits SELW-1:0 = node index. The output-select register uses field 0 only.
- `start` in 1: begin a truth-table run.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when a run completes.
- `tt_data` out W: truth-table word.
- `tt_idx` out N_IN-clog2(W) (minimum 1 bit): index of the current word.
- `tt_valid` out 1: word valid.
- `tt_ready` in 1: consumer ready.

## Operation
- Reset values:
  - `busy`, `done`, `tt_valid`, `tt_data`, `tt_idx` are all 0.
  - All gate slots and the output select are cleared to node 0, non-inverted. The default function is constant 0.
- Configuration:
  - When `cfg_we` is high and the block is in IDLE, `cfg_data` is written to `cfg_addr` at the clock edge.
  - Writes while `busy`, or to an addr > N_GATES, are ignored.
- Gate function: `w_g = MAJ(a^ia, b^ib, c^ic)`, where each operand is the selected node value XOR its invert bit.
- Function output: `f = node[out_sel] ^ out_inv`.
- State machine IDLE → EVAL → CAPTURE → (EMIT) → … → IDLE:
  - IDLE: `start` high moves to EVAL with pattern p=0, gate g=0, and clears the word accumulator. `start` is ignored outside IDLE.
  - EVAL: one gate per cycle. Gate g is computed from the current node values and written to node N_IN+1+g. Primary inputs x_i = bit i of p. After g=N_GATES-1, go to CAPTURE.
  - CAPTURE: one cycle. f is written into accumulator bit p mod W.
    - If p mod W = W-1, go to EMIT.
    - Otherwise p increments and the state returns to EVAL with g=0.
  - EMIT: `tt_valid`=1, `tt_data` = accumulator, `tt_idx` = p/W.
    - On `tt_valid && tt_ready`: if p = 2^N_IN-1, go to IDLE and pulse `done`; otherwise p increments, the accumulator clears, and the state returns to EVAL.
    - `tt_data` and `tt_idx` hold stable while `tt_valid` is high and `tt_ready` is low.
- Forward references: an operand naming gate k ≥ g reads w_k from the previous pattern. Gate nodes are cleared to 0 on `start`, so these reads are deterministic.
- Out-of-range node index (≥ NODES): the operand reads 0.
- Bit ordering: word j bit k = f(pattern j*W+k). Words are emitted in order j = 0 upward.
- `rst` during a run aborts it:
  - Outputs return to reset values.
  - Configuration is cleared.
  - No `done` is issued.

## Timing
- `busy` is high from the cycle after `start` is accepted through the cycle of the final handshake. It is low in the `done` cycle.
- Per-pattern cost: N_GATES+1 cycles. Each EMIT costs at least 1 cycle, plus any stall cycles.
- With `tt_ready` held at 1, `done` rises exactly 2^N_IN·(N_GATES+1) + 2^N_IN/W cycles after the start-accept edge. For the defaults this is 2180.
- `tt_valid` is registered. It asserts in the cycle after the CAPTURE of bit W-1.
- The first configuration write is usable by a `start` presented in the following cycle.

## Test plan
- Reset, no configuration, `start`: 4 words, all 0x00000000, with `tt_idx` = 0,1,2,3. `done` arrives at cycle 2180.
- Gate 0 = MAJ(x0,x1,x2), out_sel = w0: every word is 0xE8E8E8E8. Setting the out_sel invert bit makes every word 0x17171717.
- out_sel = x6 (node 7), no gates used: words are 0x00000000, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFF.
- Gate 0 = MAJ(x0,x1,0) (AND), gate 1 = MAJ(~w0,1,0) using node 0 inverted as constant 1, out_sel = w1: every word is 0x77777777 (NAND).
- Backpressure: hold `tt_ready` low for 10 cycles on word 1.
  - `tt_data` and `tt_idx` must stay stable throughout the stall.
  - `busy` must stay high.
  - `done` must be delayed by exactly 10 cycles, arriving at 2190.
  - `cfg_we` and `start` pulses during the stall have no effect.
- Assert `rst` during EVAL of pattern 50: all outputs go to 0 with no `done`. A new `start` then produces the all-zero table.
